// File: rtl/gcd_rr_server_if.sv
// gcd_rr_server_if: requester-side bundle of the shared GCD server.
// Carries iter_cnt only when GCD_ITER_COUNT_EN is defined.
interface gcd_rr_server_if #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [N*W-1:0] xin_flat;
    logic [N*W-1:0] yin_flat;
    logic [N-1:0]   ack;
    logic [W-1:0]   gcd_out;
    logic [IDW-1:0] out_id;
    logic           busy;
`ifdef GCD_ITER_COUNT_EN
    logic [W-1:0]   iter_cnt;
    modport master (output req, xin_flat, yin_flat, input ack, gcd_out, out_id, busy, iter_cnt);
    modport slave  (input req, xin_flat, yin_flat, output ack, gcd_out, out_id, busy, iter_cnt);
`else
    modport master (output req, xin_flat, yin_flat, input ack, gcd_out, out_id, busy);
    modport slave  (input req, xin_flat, yin_flat, output ack, gcd_out, out_id, busy);
`endif
endinterface

// File: rtl/gcd_rr_server.sv
// gcd_rr_server: one subtractive GCD engine shared round-robin among N requesters.
// Define GCD_ITER_COUNT_EN to add the saturating subtract-step counter output iter_cnt.
module gcd_rr_server #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int IDW = 2
) (
    input logic             clk,
    input logic             clr,
    gcd_rr_server_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d, gcd_q, gcd_d;
    logic [IDW-1:0] id_q, id_d, rr_ptr_q, rr_ptr_d, out_id_q, out_id_d, sel;
    logic [N-1:0]   ack_q, ack_d;
    logic           busy_q, busy_d, hit;
`ifdef GCD_ITER_COUNT_EN
    logic [W-1:0]   cnt_q, cnt_d, iter_q, iter_d;
`endif

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        hit = 1'b0;
        sel = rr_ptr_q;
        for (int k = N - 1; k >= 0; k--)
            if (bus.req[rr_ptr_q + IDW'(k)]) begin
                hit = 1'b1;
                sel = rr_ptr_q + IDW'(k);
            end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = '0;
        gcd_d    = gcd_q;
        out_id_d = out_id_q;
`ifdef GCD_ITER_COUNT_EN
        cnt_d    = cnt_q;
        iter_d   = iter_q;
`endif
        if (state_q == IDLE && hit) begin
            x_d  = bus.xin_flat[sel*W +: W];
            y_d  = bus.yin_flat[sel*W +: W];
            id_d = sel;
`ifdef GCD_ITER_COUNT_EN
            cnt_d = '0;
`endif
            if (x_d == '0 || y_d == '0) begin
                state_d  = DONE;
                ack_d    = N'(1) << sel;
                gcd_d    = x_d | y_d;
                out_id_d = sel;
`ifdef GCD_ITER_COUNT_EN
                iter_d   = '0;
`endif
            end else
                state_d = CALC;
        end else if (state_q == CALC) begin
            if (x_q == y_q) begin
                state_d  = DONE;
                ack_d    = N'(1) << id_q;
                gcd_d    = x_q;
                out_id_d = id_q;
`ifdef GCD_ITER_COUNT_EN
                iter_d   = cnt_q;
`endif
            end else begin
                x_d = (x_q > y_q) ? x_q - y_q : x_q;
                y_d = (x_q > y_q) ? y_q : y_q - x_q;
`ifdef GCD_ITER_COUNT_EN
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`endif
            end
        end else if (state_q == DONE) begin
            state_d  = IDLE;
            rr_ptr_d = id_q + 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            ack_q    <= '0;
            gcd_q    <= '0;
            out_id_q <= '0;
            busy_q   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            cnt_q    <= '0;
            iter_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
            gcd_q    <= gcd_d;
            out_id_q <= out_id_d;
            busy_q   <= busy_d;
`ifdef GCD_ITER_COUNT_EN
            cnt_q    <= cnt_d;
            iter_q   <= iter_d;
`endif
        end
    end

    assign bus.ack     = ack_q;
    assign bus.gcd_out = gcd_q;
    assign bus.out_id  = out_id_q;
    assign bus.busy    = busy_q;
`ifdef GCD_ITER_COUNT_EN
    assign bus.iter_cnt = iter_q;
`endif
endmodule

// File: tb/tb_gcd_rr_server.sv
// tb_gcd_rr_server: scoreboard bench for gcd_rr_server with a Euclid-based reference model.
// Iteration-count checks are active when GCD_ITER_COUNT_EN is defined.
module tb_gcd_rr_server;
    typedef struct packed {
        logic [1:0] id;
        logic [3:0] g;
        logic [3:0] it;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   rr_m = 0;
    exp_t exp_q[$];

    gcd_rr_server_if #(.N(4), .W(4), .IDW(2)) bif ();
    gcd_rr_server #(.N(4), .W(4), .IDW(2)) dut (.clk(clk), .clr(clr), .bus(bif));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", n, act, req);
        end
    endtask

    function automatic int gcd_f(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive steps = sum of Euclid quotients minus one.
    function automatic int steps_f(input int a, input int b);
        int s, t;
        if (a == 0 || b == 0) return 0;
        s = 0;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s - 1;
    endfunction

    function automatic int lat_f(input int a, input int b);
        return (a == 0 || b == 0) ? 1 : steps_f(a, b) + 2;
    endfunction

    task automatic push_exp(input int id, input int a, input int b);
        exp_t e;
        e.id = 2'(id);
        e.g  = 4'(gcd_f(a, b));
        e.it = 4'(steps_f(a, b));
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        bif.req = '0;
        @(negedge clk);
        chk("rst_ack", 32'(bif.ack), 0);
        chk("rst_gcd", 32'(bif.gcd_out), 0);
        chk("rst_id", 32'(bif.out_id), 0);
        chk("rst_busy", 32'(bif.busy), 0);
`ifdef GCD_ITER_COUNT_EN
        chk("rst_iter", 32'(bif.iter_cnt), 0);
`endif
        clr = 1'b0;
        rr_m = 0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Raise a set of requests together; service order is cyclic from the model pointer.
    task automatic batch(input logic [3:0] mask, input logic [15:0] xs, input logic [15:0] ys);
        int order[$];
        int id, cyc, idx, due;
        logic [15:0] xv, yv;
        xv = xs;
        yv = ys;
        for (int off = 0; off < 4; off++) begin
            id = (rr_m + off) % 4;
            if (mask[id]) begin
                order.push_back(id);
                push_exp(id, int'(xv[id*4 +: 4]), int'(yv[id*4 +: 4]));
            end
        end
        rr_m = (order[order.size()-1] + 1) % 4;
        bif.xin_flat = xs;
        bif.yin_flat = ys;
        bif.req = mask;
        cyc = 0;
        idx = 0;
        due = lat_f(int'(xv[order[0]*4 +: 4]), int'(yv[order[0]*4 +: 4]));
        while (idx < order.size() && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bif.ack != '0) begin
                chk("ack_cycle", 32'(cyc), 32'(due));
                bif.req = bif.req & ~bif.ack;
                idx++;
                if (idx < order.size())
                    due = cyc + 1 + lat_f(int'(xv[order[idx]*4 +: 4]), int'(yv[order[idx]*4 +: 4]));
            end
        end
        if (idx < order.size()) begin
            fails++;
            tests++;
            $display("FAIL batch_timeout served=%0d expected=%0d", idx, order.size());
            bif.req = '0;
        end
        @(negedge clk);
    endtask

    // Monitor: every ack is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bif.ack != '0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack got=%b expected=none", bif.ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_vec", 32'(bif.ack), 32'(4'b0001 << e.id));
                    chk("gcd_out", 32'(bif.gcd_out), 32'(e.g));
                    chk("out_id", 32'(bif.out_id), 32'(e.id));
                    chk("busy_done", 32'(bif.busy), 1);
`ifdef GCD_ITER_COUNT_EN
                    chk("iter_cnt", 32'(bif.iter_cnt), 32'(e.it));
`endif
                end
            end
        end
    end

    initial begin
        int cyc;
        bif.req = '0;
        bif.xin_flat = '0;
        bif.yin_flat = '0;
        do_reset();
        batch(4'b0001, 16'h0003, 16'h0006);
        do_reset();
        batch(4'b0101, 16'h0904, 16'h0608);
        batch(4'b1010, 16'h7050, 16'h3082);
        batch(4'b0001, 16'h0000, 16'h0005);
        batch(4'b0001, 16'h0000, 16'h0000);
        batch(4'b0010, 16'h00F0, 16'h0010);
        // Abort in the 5th CALC cycle of a 14-step operation.
        bif.xin_flat = 16'h00F0;
        bif.yin_flat = 16'h0010;
        bif.req = 4'b0010;
        repeat (5) @(negedge clk);
        chk("busy_calc", 32'(bif.busy), 1);
        clr = 1'b1;
        #1;
        chk("abort_busy", 32'(bif.busy), 0);
        chk("abort_gcd", 32'(bif.gcd_out), 0);
        chk("abort_id", 32'(bif.out_id), 0);
        chk("abort_ack", 32'(bif.ack), 0);
        bif.req = '0;
        @(negedge clk);
        clr = 1'b0;
        rr_m = 0;
        repeat (20) @(negedge clk);
        chk("idle_busy", 32'(bif.busy), 0);
        // Requester drops req after grant and its operands change mid-calculation.
        bif.xin_flat = 16'h0006;
        bif.yin_flat = 16'h0009;
        push_exp(0, 6, 9);
        rr_m = 1;
        bif.req = 4'b0001;
        @(negedge clk);
        bif.req = '0;
        @(negedge clk);
        bif.xin_flat = 16'h000F;
        cyc = 2;
        while (bif.ack == '0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("drop_ack_cycle", 32'(cyc), 4);
        @(negedge clk);
        for (int i = 0; i < 40; i++)
            batch(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom));
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
